// File: rtl/trig_pkg.sv
// Shared definitions for the multi-buffer trigger handler: FSM state
// encoding, holdoff counter width and the buffer-index width helper.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Holdoff values up to 255 fit in one byte.
    localparam int HOLD_CNT_W = 8;

    // Width of a buffer index; never narrower than one bit.
    function automatic int buf_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Holdoff counter: start zeroes it, count advances it by one per clock,
// done flags that the final holdoff cycle has been reached.
module holdoff_timer
    import trig_pkg::*;
#(
    parameter int HOLDOFF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic count,
    output logic done
);

    localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(HOLDOFF - 1);

    logic [HOLD_CNT_W-1:0] cnt;

    // Cycle counter, restarted at zero each time a holdoff begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + HOLD_CNT_W'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/multi_buffer_handler.sv
// Trigger handler for a ring of digitizer buffers: detects rising edges on
// the unmasked trigger sources, allocates the next buffer, issues a
// digitize pulse, enforces a holdoff window and counts dropped triggers.
module multi_buffer_handler
    import trig_pkg::*;
#(
    parameter int NUM_BUF = 4,
    parameter int NUM_SRC = 4,
    parameter int HOLDOFF = 16,
    localparam int IDX_W  = buf_idx_w(NUM_BUF)
) (
    input  logic               clk250_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] trig_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    input  logic               clear_i,
    input  logic [IDX_W-1:0]   clear_buffer_i,
    output logic               digitize_o,
    output logic [IDX_W-1:0]   digitize_buffer_o,
    output logic [NUM_SRC-1:0] digitize_source_o,
    output logic [NUM_BUF-1:0] buffer_status_o,
    output logic [NUM_BUF-1:0] HOLD_o,
    output logic               dead_o,
    output logic [15:0]        drop_count_o
);

    state_t             state;
    logic [IDX_W-1:0]   wr_ptr;
    logic [NUM_BUF-1:0] held;
    logic [NUM_BUF-1:0] clr_mask;
    logic [NUM_BUF-1:0] held_cleared;
    logic [NUM_BUF-1:0] wr_onehot;
    logic [NUM_SRC-1:0] trig_p0;
    logic [NUM_SRC-1:0] trig_p1;
    logic [NUM_SRC-1:0] edge_vec;
    logic               any_edge;
    logic               accept;
    logic               dead_nxt;
    logic               hold_done;

    // Sample the trigger levels once, then keep one cycle of history.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            trig_p0 <= '0;
            trig_p1 <= '0;
        end else begin
            trig_p0 <= trig_i;
            trig_p1 <= trig_p0;
        end
    end

    assign edge_vec = trig_p0 & ~trig_p1 & ~src_mask_i;
    assign any_edge = |edge_vec;

    // A clear takes effect before the allocation check of the same cycle.
    always_comb begin
        clr_mask = '0;
        if (clear_i) begin
            clr_mask = NUM_BUF'(1) << clear_buffer_i;
        end
        wr_onehot    = NUM_BUF'(1) << wr_ptr;
        held_cleared = held & ~clr_mask;
    end

    assign accept = (state == ST_IDLE) && any_edge && !held_cleared[wr_ptr];

    // On accept the FSM leaves IDLE, so dead is high regardless of the
    // next buffer; otherwise wr_ptr is unchanged and its cleared status
    // decides.
    assign dead_nxt = accept
                    || (state == ST_ACCEPT)
                    || ((state == ST_HOLDOFF) && !hold_done)
                    || held_cleared[wr_ptr];

    holdoff_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_holdoff_timer (
        .clk   (clk250_i),
        .rst   (rst_i),
        .start (state == ST_ACCEPT),
        .count (state == ST_HOLDOFF),
        .done  (hold_done)
    );

    // Trigger FSM with buffer allocation and all registered outputs.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            wr_ptr            <= '0;
            held              <= '0;
            digitize_o        <= 1'b0;
            digitize_buffer_o <= '0;
            digitize_source_o <= '0;
            dead_o            <= 1'b0;
            drop_count_o      <= '0;
        end else begin
            digitize_o <= 1'b0;
            dead_o     <= dead_nxt;
            held       <= held_cleared;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        held              <= held_cleared | wr_onehot;
                        digitize_o        <= 1'b1;
                        digitize_buffer_o <= wr_ptr;
                        digitize_source_o <= edge_vec;
                        wr_ptr            <= wr_ptr + IDX_W'(1);
                        state             <= ST_ACCEPT;
                    end else if (any_edge && (drop_count_o != 16'hFFFF)) begin
                        drop_count_o <= drop_count_o + 16'd1;
                    end
                end
                ST_ACCEPT: begin
                    state <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (hold_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign buffer_status_o = held;
    assign HOLD_o          = held;

endmodule

// File: tb/tb_multi_buffer_handler.sv
// Self-checking bench for multi_buffer_handler with default parameters.
// Expected digitize events are queued when triggers are driven and
// compared when the DUT pulses digitize_o.
module tb_multi_buffer_handler;

    logic       clk250_i = 1'b0;
    logic       rst_i;
    logic [3:0] trig_i;
    logic [3:0] src_mask_i;
    logic       clear_i;
    logic [1:0] clear_buffer_i;
    logic       digitize_o;
    logic [1:0] digitize_buffer_o;
    logic [3:0] digitize_source_o;
    logic [3:0] buffer_status_o;
    logic [3:0] HOLD_o;
    logic       dead_o;
    logic [15:0] drop_count_o;

    typedef struct packed {
        logic [1:0] b;
        logic [3:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    multi_buffer_handler dut (
        .clk250_i          (clk250_i),
        .rst_i             (rst_i),
        .trig_i            (trig_i),
        .src_mask_i        (src_mask_i),
        .clear_i           (clear_i),
        .clear_buffer_i    (clear_buffer_i),
        .digitize_o        (digitize_o),
        .digitize_buffer_o (digitize_buffer_o),
        .digitize_source_o (digitize_source_o),
        .buffer_status_o   (buffer_status_o),
        .HOLD_o            (HOLD_o),
        .dead_o            (dead_o),
        .drop_count_o      (drop_count_o)
    );

    always #2 clk250_i = ~clk250_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk250_i);
    endtask

    task automatic push_exp(input logic [1:0] b, input logic [3:0] s);
        exp_t e;
        e.b = b;
        e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk250_i);
        rst_i          = 1'b1;
        trig_i         = '0;
        src_mask_i     = '0;
        clear_i        = 1'b0;
        clear_buffer_i = '0;
        step(2);
        rst_i = 1'b0;
        step(2);
    endtask

    // Scoreboard: every digitize pulse must match the oldest queued event.
    always @(negedge clk250_i) begin
        if (digitize_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dig_unexpected", 32'(digitize_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dig_buf", 32'(digitize_buffer_o), 32'(e.b));
                chk("dig_src", 32'(digitize_source_o), 32'(e.s));
            end
        end
    end

    initial begin
        int cnt;
        rst_i          = 1'b1;
        trig_i         = '0;
        src_mask_i     = '0;
        clear_i        = 1'b0;
        clear_buffer_i = '0;
        step(3);

        // Reset state
        chk("rst_hold",   32'(HOLD_o), 32'd0);
        chk("rst_status", 32'(buffer_status_o), 32'd0);
        chk("rst_dig",    32'(digitize_o), 32'd0);
        chk("rst_dead",   32'(dead_o), 32'd0);
        chk("rst_drop",   32'(drop_count_o), 32'd0);
        chk("rst_buf",    32'(digitize_buffer_o), 32'd0);
        chk("rst_src",    32'(digitize_source_o), 32'd0);

        // Single edge: latency, hold, dead length
        do_reset();
        trig_i = 4'b0001;
        push_exp(2'd0, 4'b0001);
        step(1);
        chk("a_dig_early", 32'(digitize_o), 32'd0);
        step(1);
        chk("a_dig",  32'(digitize_o), 32'd1);
        chk("a_hold", 32'(HOLD_o), 32'h1);
        cnt = 0;
        while (dead_o && cnt < 100) begin
            cnt++;
            step(1);
        end
        chk("a_dead_len", 32'(cnt), 32'd17);
        trig_i = '0;
        chk("a_drop",       32'(drop_count_o), 32'd0);
        chk("a_buf_stable", 32'(digitize_buffer_o), 32'd0);
        chk("a_src_stable", 32'(digitize_source_o), 32'h1);
        chk("a_dead_idle",  32'(dead_o), 32'd0);

        // Edge during holdoff is ignored, not dropped
        do_reset();
        trig_i = 4'b0001;
        push_exp(2'd0, 4'b0001);
        step(2);
        trig_i = '0;
        step(3);
        trig_i = 4'b0010;
        step(30);
        chk("b_drop", 32'(drop_count_o), 32'd0);
        chk("b_hold", 32'(HOLD_o), 32'h1);
        trig_i = 4'b0011;
        push_exp(2'd1, 4'b0001);
        step(20);
        chk("b_hold2", 32'(HOLD_o), 32'h3);
        trig_i = '0;

        // Fill all buffers, fifth edge dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            trig_i = 4'b0001;
            if (i < 4) push_exp(2'(i), 4'b0001);
            step(2);
            trig_i = '0;
            step(18);
        end
        chk("c_hold",   32'(HOLD_o), 32'hF);
        chk("c_status", 32'(buffer_status_o), 32'hF);
        chk("c_drop",   32'(drop_count_o), 32'd1);
        chk("c_dead",   32'(dead_o), 32'd1);

        // Clear of buffer 0 in the same cycle as an edge is accepted
        trig_i = 4'b0001;
        step(1);
        clear_i        = 1'b1;
        clear_buffer_i = 2'd0;
        push_exp(2'd0, 4'b0001);
        step(1);
        clear_i = 1'b0;
        chk("d_hold", 32'(HOLD_o), 32'hF);
        chk("d_drop", 32'(drop_count_o), 32'd1);
        trig_i = '0;
        step(20);
        clear_i        = 1'b1;
        clear_buffer_i = 2'd2;
        step(1);
        clear_i = 1'b0;
        chk("d_clr2",        32'(HOLD_o), 32'hB);
        chk("d_clr2_status", 32'(buffer_status_o), 32'hB);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("d_clr2_again", 32'(HOLD_o), 32'hB);
        chk("d_dead_held",  32'(dead_o), 32'd1);
        clear_i        = 1'b1;
        clear_buffer_i = 2'd1;
        step(1);
        clear_i = 1'b0;
        chk("d_clr1",      32'(HOLD_o), 32'h9);
        chk("d_dead_free", 32'(dead_o), 32'd0);

        // Masking and simultaneous sources
        do_reset();
        src_mask_i = 4'b0010;
        trig_i     = 4'b1010;
        push_exp(2'd0, 4'b1000);
        step(20);
        src_mask_i = '0;
        trig_i     = '0;
        step(2);
        trig_i = 4'b0101;
        push_exp(2'd1, 4'b0101);
        step(20);
        chk("e_hold", 32'(HOLD_o), 32'h3);
        trig_i = '0;
        step(2);
        src_mask_i = 4'b0001;
        trig_i     = 4'b0001;
        step(20);
        chk("e_masked_hold", 32'(HOLD_o), 32'h3);
        chk("e_masked_drop", 32'(drop_count_o), 32'd0);
        trig_i     = '0;
        src_mask_i = '0;

        // Reset during holdoff with two buffers held
        do_reset();
        trig_i = 4'b0001;
        push_exp(2'd0, 4'b0001);
        step(2);
        trig_i = '0;
        step(18);
        trig_i = 4'b0001;
        push_exp(2'd1, 4'b0001);
        step(2);
        trig_i = '0;
        step(3);
        chk("f_pre_hold", 32'(HOLD_o), 32'h3);
        rst_i = 1'b1;
        #1;
        chk("f_rst_hold",   32'(HOLD_o), 32'd0);
        chk("f_rst_status", 32'(buffer_status_o), 32'd0);
        chk("f_rst_dig",    32'(digitize_o), 32'd0);
        chk("f_rst_dead",   32'(dead_o), 32'd0);
        chk("f_rst_drop",   32'(drop_count_o), 32'd0);
        chk("f_rst_buf",    32'(digitize_buffer_o), 32'd0);
        chk("f_rst_src",    32'(digitize_source_o), 32'd0);
        trig_i = 4'b0100;
        step(2);
        push_exp(2'd0, 4'b0100);
        rst_i = 1'b0;
        step(20);
        chk("f_hold", 32'(HOLD_o), 32'h1);
        chk("f_dead", 32'(dead_o), 32'd0);
        trig_i = '0;
        step(2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
